// File: rtl/awb_pkg.sv
// ============================================================================
// Module   : awb_pkg
// Brief    : Shared widths, constants, FSM encoding and gain post-processing
//            for the gray-world AWB gain scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package awb_pkg;

  localparam int SUM_W  = 29;
  localparam int FRAC_W = 8;
  localparam int GAIN_W = 10;
  localparam int NUM_W  = SUM_W + 2 + FRAC_W;
  localparam int DEN_W  = SUM_W + 2;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 10'd256;
  localparam logic [GAIN_W-1:0] GAIN_MAX   = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TOTAL  = 3'd1,
    S_DIV_R  = 3'd2,
    S_DIV_G  = 3'd3,
    S_DIV_B  = 3'd4,
    S_UPDATE = 3'd5
  } awb_state_e;

  function automatic logic [DEN_W-1:0] den_x3(input logic [SUM_W-1:0] s);
    return ({2'b00, s} << 1) + {2'b00, s};
  endfunction

  // A zero channel sum forces unity; the divider's all-ones answer is ignored.
  function automatic logic [GAIN_W-1:0] post_gain(input logic [NUM_W-1:0] quo,
                                                  input logic sum_zero);
    if (sum_zero)
      return GAIN_UNITY;
    else if (quo > {{(NUM_W-GAIN_W){1'b0}}, GAIN_MAX})
      return GAIN_MAX;
    else
      return quo[GAIN_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/awb_div_seq.sv
// ============================================================================
// Module   : awb_div_seq
// Brief    : Restoring divider, one quotient bit per cycle, fixed latency of
//            one load cycle plus NUM_W iterate cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module awb_div_seq
  import awb_pkg::*;
(
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] c_iter = CNT_W'(NUM_W);

  logic [DEN_W-1:0] r_den;
  logic [DEN_W-1:0] r_rem;
  logic [NUM_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [DEN_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DEN_W-1:0] w_rem_sub;

  // Dividend bits leave from the top of r_quo while quotient bits enter below.
  assign w_rem_sh  = {r_rem, r_quo[NUM_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_den});
  assign w_rem_sub = w_rem_sh[DEN_W-1:0] - r_den;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_den  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_den <= i_den;
        r_rem <= '0;
        r_quo <= i_num;
        r_cnt <= c_iter;
      end else if (r_cnt != '0) begin
        r_rem  <= w_ge ? w_rem_sub : w_rem_sh[DEN_W-1:0];
        r_quo  <= {r_quo[NUM_W-2:0], w_ge};
        r_cnt  <= r_cnt - CNT_W'(1);
        r_done <= (r_cnt == CNT_W'(1));
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;

endmodule

`default_nettype wire

// File: rtl/awb_gain_sched.sv
// ============================================================================
// Module   : awb_gain_sched
// Brief    : Per-frame gray-world AWB gain scheduler sharing one sequential
//            divider across R, G and B; publishes Q2.8 gains atomically.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module awb_gain_sched
  import awb_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_awb_en,
  input  logic              I_sum_vld,
  input  logic [SUM_W-1:0]  I_sum_r,
  input  logic [SUM_W-1:0]  I_sum_g,
  input  logic [SUM_W-1:0]  I_sum_b,
  output logic [GAIN_W-1:0] O_gain_r,
  output logic [GAIN_W-1:0] O_gain_g,
  output logic [GAIN_W-1:0] O_gain_b,
  output logic              O_gain_vld,
  output logic              O_busy,
  output logic              O_overrun
);

  awb_state_e r_state, w_state_nxt;

  logic             r_pend;
  logic [SUM_W-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic [SUM_W-1:0] r_work_r, r_work_g, r_work_b;
  logic [NUM_W-1:0] r_num;
  logic [GAIN_W-1:0] r_q_r, r_q_g;
  logic [GAIN_W-1:0] r_gain_r, r_gain_g, r_gain_b;
  logic             r_gain_vld, r_overrun;

  logic             w_consume;
  logic [DEN_W-1:0] w_total;
  logic [NUM_W-1:0] w_num;
  logic             w_div_start, w_div_done;
  logic [NUM_W-1:0] w_div_num, w_div_quo;
  logic [DEN_W-1:0] w_div_den;
  logic             w_cur_zero;
  logic [GAIN_W-1:0] w_q_cur;

  assign w_consume = (r_state == S_IDLE) && r_pend;
  assign w_total   = {2'b00, r_work_r} + {2'b00, r_work_g} + {2'b00, r_work_b};
  assign w_num     = {w_total, {FRAC_W{1'b0}}};

  // A new set loaded in the same cycle the FSM takes the old one is not an overrun.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pend    <= 1'b0;
      r_pend_r  <= '0;
      r_pend_g  <= '0;
      r_pend_b  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= I_sum_vld && r_pend && !w_consume;
      if (I_sum_vld) begin
        r_pend   <= 1'b1;
        r_pend_r <= I_sum_r;
        r_pend_g <= I_sum_g;
        r_pend_b <= I_sum_b;
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_div_num   = r_num;
    w_div_den   = '0;
    w_cur_zero  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) w_state_nxt = S_TOTAL;
      end
      S_TOTAL: begin
        w_div_start = 1'b1;
        w_div_num   = w_num;
        w_div_den   = den_x3(r_work_r);
        w_state_nxt = S_DIV_R;
      end
      S_DIV_R: begin
        w_cur_zero = (r_work_r == '0);
        w_div_den  = den_x3(r_work_g);
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_state_nxt = S_DIV_G;
        end
      end
      S_DIV_G: begin
        w_cur_zero = (r_work_g == '0);
        w_div_den  = den_x3(r_work_b);
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_state_nxt = S_DIV_B;
        end
      end
      S_DIV_B: begin
        w_cur_zero = (r_work_b == '0);
        if (w_div_done) w_state_nxt = S_UPDATE;
      end
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_q_cur = post_gain(w_div_quo, w_cur_zero);

  awb_div_seq u_div (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .i_start (w_div_start),
    .i_num   (w_div_num),
    .i_den   (w_div_den),
    .o_done  (w_div_done),
    .o_quo   (w_div_quo)
  );

  // All three gains commit on one edge; the pulse is visible during UPDATE.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= S_IDLE;
      r_work_r   <= '0;
      r_work_g   <= '0;
      r_work_b   <= '0;
      r_num      <= '0;
      r_q_r      <= GAIN_UNITY;
      r_q_g      <= GAIN_UNITY;
      r_gain_r   <= GAIN_UNITY;
      r_gain_g   <= GAIN_UNITY;
      r_gain_b   <= GAIN_UNITY;
      r_gain_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gain_vld <= 1'b0;
      if (w_consume) begin
        r_work_r <= r_pend_r;
        r_work_g <= r_pend_g;
        r_work_b <= r_pend_b;
      end
      if (r_state == S_TOTAL) r_num <= w_num;
      if (r_state == S_DIV_R && w_div_done) r_q_r <= w_q_cur;
      if (r_state == S_DIV_G && w_div_done) r_q_g <= w_q_cur;
      if (r_state == S_DIV_B && w_div_done) begin
        r_gain_vld <= 1'b1;
        r_gain_r   <= I_awb_en ? r_q_r   : GAIN_UNITY;
        r_gain_g   <= I_awb_en ? r_q_g   : GAIN_UNITY;
        r_gain_b   <= I_awb_en ? w_q_cur : GAIN_UNITY;
      end
    end
  end

  assign O_gain_r   = r_gain_r;
  assign O_gain_g   = r_gain_g;
  assign O_gain_b   = r_gain_b;
  assign O_gain_vld = r_gain_vld;
  assign O_busy     = (r_state != S_IDLE);
  assign O_overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_awb_gain_sched.sv
// ============================================================================
// Module   : tb_awb_gain_sched
// Brief    : Vector table plus scoreboard bench for awb_gain_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_awb_gain_sched;
  import awb_pkg::*;

  logic              I_clk = 1'b0;
  logic              I_rst_n;
  logic              I_awb_en;
  logic              I_sum_vld;
  logic [SUM_W-1:0]  I_sum_r, I_sum_g, I_sum_b;
  logic [GAIN_W-1:0] O_gain_r, O_gain_g, O_gain_b;
  logic              O_gain_vld, O_busy, O_overrun;

  awb_gain_sched dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_awb_en   (I_awb_en),
    .I_sum_vld  (I_sum_vld),
    .I_sum_r    (I_sum_r),
    .I_sum_g    (I_sum_g),
    .I_sum_b    (I_sum_b),
    .O_gain_r   (O_gain_r),
    .O_gain_g   (O_gain_g),
    .O_gain_b   (O_gain_b),
    .O_gain_vld (O_gain_vld),
    .O_busy     (O_busy),
    .O_overrun  (O_overrun)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [SUM_W-1:0]  r, g, b;
    logic              en;
    logic [GAIN_W-1:0] er, eg, eb;
  } vec_t;

  typedef struct {
    logic [GAIN_W-1:0] er, eg, eb;
    int                start;
    bit                chk_lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_vld = 0;
  int   n_ovr = 0;

  always @(posedge I_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Scoreboard consumer: every gain update must match the oldest expectation.
  always @(negedge I_clk) begin
    exp_t e;
    if (O_overrun) n_ovr++;
    if (O_gain_vld) begin
      n_vld++;
      if (sb.size() == 0) begin
        chk("unexpected_gain_vld", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("gain_r", O_gain_r, e.er);
        chk("gain_g", O_gain_g, e.eg);
        chk("gain_b", O_gain_b, e.eb);
        if (e.chk_lat) chk("latency", cyc - e.start, 122);
      end
    end
  end

  task automatic send(input logic [SUM_W-1:0] r, g, b,
                      input logic [GAIN_W-1:0] er, eg, eb,
                      input bit push, input bit lat);
    @(negedge I_clk);
    I_sum_r   = r;
    I_sum_g   = g;
    I_sum_b   = b;
    I_sum_vld = 1'b1;
    if (push) sb.push_back('{er, eg, eb, cyc + 1, lat});
    @(negedge I_clk);
    I_sum_vld = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge I_clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge I_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{29'd1000,      29'd1000,      29'd1000,      1'b1, 10'd256,  10'd256,  10'd256};
    vecs[1] = '{29'd1000,      29'd2000,      29'd3000,      1'b1, 10'd512,  10'd256,  10'd170};
    vecs[2] = '{29'd1,         29'd1000,      29'd1000,      1'b1, 10'd1023, 10'd170,  10'd170};
    vecs[3] = '{29'd0,         29'd300,       29'd300,       1'b1, 10'd256,  10'd170,  10'd170};
    vecs[4] = '{29'd1000,      29'd2000,      29'd3000,      1'b0, 10'd256,  10'd256,  10'd256};
    vecs[5] = '{29'h1FFFFFFF,  29'h1FFFFFFF,  29'h1FFFFFFF,  1'b1, 10'd256,  10'd256,  10'd256};
    vecs[6] = '{29'h1FFFFFFF,  29'd1,         29'd1,         1'b1, 10'd85,   10'd1023, 10'd1023};

    I_rst_n   = 1'b0;
    I_awb_en  = 1'b1;
    I_sum_vld = 1'b0;
    I_sum_r   = '0;
    I_sum_g   = '0;
    I_sum_b   = '0;
    repeat (3) @(negedge I_clk);
    chk("rst_gain_r", O_gain_r, 256);
    chk("rst_gain_g", O_gain_g, 256);
    chk("rst_gain_b", O_gain_b, 256);
    chk("rst_busy", O_busy, 0);
    chk("rst_gain_vld", O_gain_vld, 0);
    chk("rst_overrun", O_overrun, 0);
    I_rst_n = 1'b1;
    repeat (2) @(negedge I_clk);

    for (int i = 0; i < 7; i++) begin
      I_awb_en = vecs[i].en;
      send(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].er, vecs[i].eg, vecs[i].eb, 1'b1, 1'b1);
      repeat (50) @(negedge I_clk);
      chk("busy_mid", O_busy, 1);
      wait_drain(300);
      chk("busy_idle", O_busy, 0);
    end
    I_awb_en = 1'b1;

    // Three sets 10 cycles apart: the second is overwritten by the third.
    n_ovr = 0;
    n_vld = 0;
    send(29'd1000, 29'd2000, 29'd3000, 10'd512, 10'd256, 10'd170, 1'b1, 1'b1);
    repeat (8) @(negedge I_clk);
    send(29'd5, 29'd5, 29'd5, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
    repeat (8) @(negedge I_clk);
    send(29'd1, 29'd1000, 29'd1000, 10'd1023, 10'd170, 10'd170, 1'b1, 1'b0);
    wait_drain(600);
    repeat (20) @(negedge I_clk);
    chk("overrun_pulses", n_ovr, 1);
    chk("gain_vld_pulses", n_vld, 2);

    // Reset in the middle of the G division.
    send(29'd1000, 29'd2000, 29'd3000, 10'd512, 10'd256, 10'd170, 1'b1, 1'b1);
    repeat (60) @(negedge I_clk);
    chk("busy_before_rst", O_busy, 1);
    #2 I_rst_n = 1'b0;
    #1;
    chk("midrst_gain_r", O_gain_r, 256);
    chk("midrst_gain_g", O_gain_g, 256);
    chk("midrst_gain_b", O_gain_b, 256);
    chk("midrst_busy", O_busy, 0);
    sb.delete();
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (2) @(negedge I_clk);
    send(29'd1000, 29'd2000, 29'd3000, 10'd512, 10'd256, 10'd170, 1'b1, 1'b1);
    wait_drain(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/awb_gain_sched.md
Name: awb_gain_sched

Overview:
- Per-frame gain scheduler for the gray-world auto-white-balance path.
- Accepts the three channel sums latched at frame end and time-shares one sequential divider across R, G and B.
- Computes gain_c = (R+G+B) / (3*sum_c) in unsigned Q2.8 and publishes the three gains atomically to the downstream per-pixel multiply stage.
- Replaces three per-pixel dividers with one divider used once per frame.

Parameters:
SUM_W, 29, width of each channel sum (holds 1920*1080*255)
FRAC_W, 8, fractional bits of gain
GAIN_W, 10, gain width (Q2.8, max 1023 = 3.996)

Ports:
I_clk  in  1  clock
I_rst_n  in  1  async active-low reset
I_awb_en  in  1  1 = computed gains, 0 = unity gains
I_sum_vld  in  1  one-cycle strobe, sums valid
I_sum_r  in  SUM_W  red sum
I_sum_g  in  SUM_W  green sum
I_sum_b  in  SUM_W  blue sum
O_gain_r  out  GAIN_W  red gain Q2.8
O_gain_g  out  GAIN_W  green gain Q2.8
O_gain_b  out  GAIN_W  blue gain Q2.8
O_gain_vld  out  1  one-cycle pulse when gains update
O_busy  out  1  computation in progress
O_overrun  out  1  one-cycle pulse, pending set overwritten

Behaviour:
- Reset: the clock is I_clk; reset I_rst_n is asynchronous, active-low. At reset, gains = 256 (unity), O_gain_vld = 0, O_busy = 0, O_overrun = 0, FSM = IDLE, pending flag cleared.
- Input capture: on I_sum_vld, the three sums are registered into a pending buffer and the pending flag is set.
- Single-depth pending buffer:
  - I_sum_vld while pending already set and FSM not consuming it: buffer overwritten, O_overrun pulses on the next cycle.
  - In-flight computation is never disturbed.
- FSM states: IDLE, TOTAL, DIV_R, DIV_G, DIV_B, UPDATE.
  - IDLE -> TOTAL when pending set; working sums copied, pending cleared in the same cycle.
  - TOTAL: one cycle. total = r+g+b, width SUM_W+2. numerator N = total<<FRAC_W, width SUM_W+2+FRAC_W = 39.
  - DIV_x: denominator D = 3*sum_x, width SUM_W+2, computed as (sum<<1)+sum.
    - Issue start to the divider, wait for done; then DIV_R -> DIV_G -> DIV_B -> UPDATE.
    - Each division takes exactly 1 load cycle plus NUM_W = 39 iterate cycles, i.e. 40 cycles.
  - UPDATE: one cycle. All three gain registers load simultaneously, O_gain_vld pulses, FSM -> IDLE. A set pending flag restarts TOTAL on the following cycle.
- Latency: O_gain_vld asserts exactly 122 cycles after the cycle in which I_sum_vld is sampled (1 capture + 1 TOTAL + 3*40 DIV), with defaults.
- O_busy = 1 in every state except IDLE.
- Quotient post-processing, per channel, in this order:
  - sum_x == 0 -> gain 256; the divider is still run for fixed timing.
  - quotient > 1023 -> saturate to 1023.
  - otherwise quotient[GAIN_W-1:0], truncated (no rounding).
- Bypass:
  - I_awb_en = 0 sampled in UPDATE -> all gains load 256 and O_gain_vld still pulses.
  - I_awb_en has no effect on the pending buffer or on FSM timing.
- Gains are stable between O_gain_vld pulses; no partial updates are ever visible.

Decomposition:
- Package awb_pkg: SUM_W, FRAC_W, GAIN_W, NUM_W = SUM_W+2+FRAC_W, DEN_W = SUM_W+2, GAIN_UNITY = 256, GAIN_MAX = 1023, FSM state enum.
- Sub-module awb_div_seq: restoring divider, 1 quotient bit per cycle.
  - Ports: start, num[NUM_W], den[DEN_W], done pulse, quo[NUM_W].
  - Fixed 40-cycle latency.
  - den == 0 yields all-ones quotient; the parent overrides this case with unity.

Test Plan:
- Reset -> gains 256/256/256, O_busy 0. Then sums 1000/1000/1000 -> O_gain_vld at +122 cycles, gains 256/256/256.
- Sums R=1000, G=2000, B=3000 -> gains R=512, G=256, B=170 (truncated from 170.67).
- Sums R=1, G=1000, B=1000 -> R=1023 (saturated from 170752), G=170, B=170.
- Sums R=0, G=300, B=300 -> R=256 (zero rule), G=170, B=170; latency is still 122.
- Three I_sum_vld pulses 10 cycles apart, with the first computation in progress:
  - O_overrun pulses once.
  - Exactly two O_gain_vld pulses occur; the second reflects the third sum set.
- I_awb_en=0 with sums 1000/2000/3000 -> gains 256/256/256, and O_gain_vld still pulses.
- Reset asserted mid-DIV_G -> outputs return to reset values immediately; the next valid set produces correct gains.
